// File: rtl/uart_buf_pkg.sv
// Shared types and sizing helpers for the UART TX/RX data buffer.
package uart_buf_pkg;

  // Bit index of each channel within the ovf/udf flag vectors.
  typedef enum logic {
    CH_TX = 1'b0,
    CH_RX = 1'b1
  } ch_e;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_buf_if.sv
// Bus/UART-facing handshake bundle of the data buffer (TX and RX channels).
interface uart_buf_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = uart_buf_pkg::cnt_w(DEPTH);

  logic          tx_wr;
  logic [W-1:0]  tx_wdata;
  logic          tx_full;
  logic          tx_valid;
  logic          tx_ready;
  logic [W-1:0]  tx_rdata;
  logic          rx_wr;
  logic [W-1:0]  rx_wdata;
  logic          rx_full;
  logic          rx_valid;
  logic          rx_ready;
  logic [W-1:0]  rx_rdata;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic [1:0]    ovf;
  logic [1:0]    udf;

  // Driven by the bus / UART core.
  modport master (
    output tx_wr, tx_wdata, tx_ready, rx_wr, rx_wdata, rx_ready,
    input  tx_full, tx_valid, tx_rdata, rx_full, rx_valid, rx_rdata,
    input  tx_count, rx_count, ovf, udf
  );

  // Implemented by the buffer.
  modport slave (
    input  tx_wr, tx_wdata, tx_ready, rx_wr, rx_wdata, rx_ready,
    output tx_full, tx_valid, tx_rdata, rx_full, rx_valid, rx_rdata,
    output tx_count, rx_count, ovf, udf
  );

endinterface

// File: rtl/uart_buf_fifo.sv
// First-word-fall-through FIFO with occupancy count, drop and underflow pulses.
module uart_buf_fifo
  import uart_buf_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  output logic                     full,
  output logic                     valid,
  input  logic                     ready,
  output logic [W-1:0]             rdata,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     drop_c,
  output logic                     udf_c
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_buf_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          valid_q;
  logic          full_q;
  logic          pop_c;
  logic          push_c;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    pop_c      = valid_q & ready & ~clr;
    push_c     = wr & ~clr & (~full_q | (valid_q & ready));
    drop_c     = wr & ~clr & full_q & ~(valid_q & ready);
    udf_c      = ready & ~clr & ~valid_q;
    count_next = count_q;
    if (clr) begin
      count_next = '0;
    end else if (push_c && !pop_c) begin
      count_next = count_q + CW'(1);
    end else if (pop_c && !push_c) begin
      count_next = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
        if (push_c) wr_ptr <= wr_ptr + PW'(1);
      end
      count_q <= count_next;
      valid_q <= (count_next != '0);
      full_q  <= (count_next == CW'(DEPTH));
    end
  end

  // Storage is intentionally left unreset; valid gates its visibility.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wdata;
  end

  assign rdata = valid_q ? mem[rd_ptr] : '0;
  assign valid = valid_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/uart_data_buffer.sv
// TX/RX data buffering between bus register file and UART core.
// Optional sticky overflow/underflow flags enabled by UART_BUF_STATUS_EN.
module uart_data_buffer
  import uart_buf_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  uart_buf_if.slave  bus
);
  logic tx_drop;
  logic tx_udf;
  logic rx_drop;
  logic rx_udf;

  uart_buf_fifo #(.W(W), .DEPTH(DEPTH)) u_tx (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clr    (clr_i),
    .wr     (bus.tx_wr),
    .wdata  (bus.tx_wdata),
    .full   (bus.tx_full),
    .valid  (bus.tx_valid),
    .ready  (bus.tx_ready),
    .rdata  (bus.tx_rdata),
    .count  (bus.tx_count),
    .drop_c (tx_drop),
    .udf_c  (tx_udf)
  );

  uart_buf_fifo #(.W(W), .DEPTH(DEPTH)) u_rx (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clr    (clr_i),
    .wr     (bus.rx_wr),
    .wdata  (bus.rx_wdata),
    .full   (bus.rx_full),
    .valid  (bus.rx_valid),
    .ready  (bus.rx_ready),
    .rdata  (bus.rx_rdata),
    .count  (bus.rx_count),
    .drop_c (rx_drop),
    .udf_c  (rx_udf)
  );

`ifdef UART_BUF_STATUS_EN
  logic [1:0] ovf_q;
  logic [1:0] udf_q;

  // Sticky error flags, cleared only by clr_i or reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 2'b00;
      udf_q <= 2'b00;
    end else if (clr_i) begin
      ovf_q <= 2'b00;
      udf_q <= 2'b00;
    end else begin
      ovf_q[CH_TX] <= ovf_q[CH_TX] | tx_drop;
      ovf_q[CH_RX] <= ovf_q[CH_RX] | rx_drop;
      udf_q[CH_TX] <= udf_q[CH_TX] | tx_udf;
      udf_q[CH_RX] <= udf_q[CH_RX] | rx_udf;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  logic unused_flags;
  assign unused_flags = ^{tx_drop, tx_udf, rx_drop, rx_udf};
  assign bus.ovf      = 2'b00;
  assign bus.udf      = 2'b00;
`endif

endmodule

// File: tb/tb_uart_data_buffer.sv
// Directed self-checking bench for uart_data_buffer (W=32, DEPTH=4).
module tb_uart_data_buffer;
`ifdef UART_BUF_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic clr_i = 1'b0;
  int   checks = 0;
  int   passes = 0;

  uart_buf_if #(.W(32), .DEPTH(4)) bus ();

  uart_data_buffer #(.W(32), .DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_tx(input logic [31:0] d);
    bus.tx_wr = 1'b1; bus.tx_wdata = d; tick(); bus.tx_wr = 1'b0;
  endtask

  task automatic push_rx(input logic [31:0] d);
    bus.rx_wr = 1'b1; bus.rx_wdata = d; tick(); bus.rx_wr = 1'b0;
  endtask

  task automatic pop_tx();
    bus.tx_ready = 1'b1; tick(); bus.tx_ready = 1'b0;
  endtask

  task automatic expect_tx_head(input string name, input logic [31:0] exp);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_rdata !== exp)
      $display("FAIL %s: valid=%b data=%h, want valid=1 data=%h", name, bus.tx_valid, bus.tx_rdata, exp);
    else passes++;
  endtask

  task automatic test_reset();
    push_tx(32'h01); push_tx(32'h02); push_tx(32'h03);
    push_rx(32'h04);
    bus.rx_ready = 1'b1; tick(); tick(); bus.rx_ready = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (bus.tx_count !== 3'd0 || bus.rx_count !== 3'd0)
      $display("FAIL reset_count: tx=%0d rx=%0d, want 0 0", bus.tx_count, bus.rx_count);
    else passes++;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.rx_valid !== 1'b0 || bus.tx_full !== 1'b0 || bus.rx_full !== 1'b0)
      $display("FAIL reset_valid: txv=%b rxv=%b txf=%b rxf=%b, want 0", bus.tx_valid, bus.rx_valid, bus.tx_full, bus.rx_full);
    else passes++;
    checks++;
    if (bus.tx_rdata !== 32'h0 || bus.rx_rdata !== 32'h0)
      $display("FAIL reset_data: tx=%h rx=%h, want 0", bus.tx_rdata, bus.rx_rdata);
    else passes++;
    checks++;
    if (bus.ovf !== 2'b00 || bus.udf !== 2'b00)
      $display("FAIL reset_flags: ovf=%b udf=%b, want 00 00", bus.ovf, bus.udf);
    else passes++;
    tick(); tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    push_tx(32'hA1); push_tx(32'hA2); push_tx(32'hA3);
    checks++;
    if (bus.tx_full !== 1'b0 || bus.tx_count !== 3'd3)
      $display("FAIL fill3: full=%b count=%0d, want 0 3", bus.tx_full, bus.tx_count);
    else passes++;
    push_tx(32'hA4);
    checks++;
    if (bus.tx_full !== 1'b1 || bus.tx_count !== 3'd4)
      $display("FAIL fill4: full=%b count=%0d, want 1 4", bus.tx_full, bus.tx_count);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      expect_tx_head("drain_order", 32'hA1 + 32'(i));
      pop_tx();
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_rdata !== 32'h0 || bus.tx_count !== 3'd0 || bus.tx_full !== 1'b0)
      $display("FAIL drain_empty: valid=%b data=%h count=%0d full=%b, want 0 0 0 0",
               bus.tx_valid, bus.tx_rdata, bus.tx_count, bus.tx_full);
    else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) push_tx(32'hA1 + 32'(i));
    push_tx(32'hFF);
    checks++;
    if (bus.tx_count !== 3'd4 || bus.tx_full !== 1'b1)
      $display("FAIL ovf_count: count=%0d full=%b, want 4 1", bus.tx_count, bus.tx_full);
    else passes++;
    checks++;
    if (bus.ovf !== (STAT ? 2'b01 : 2'b00) || bus.udf !== 2'b00)
      $display("FAIL ovf_flag: ovf=%b udf=%b, want %b 00", bus.ovf, bus.udf, STAT ? 2'b01 : 2'b00);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      expect_tx_head("ovf_order", 32'hA1 + 32'(i));
      pop_tx();
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.ovf !== (STAT ? 2'b01 : 2'b00))
      $display("FAIL ovf_after: valid=%b ovf=%b, want 0 %b", bus.tx_valid, bus.ovf, STAT ? 2'b01 : 2'b00);
    else passes++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) push_tx(32'hA1 + 32'(i));
    bus.tx_wr = 1'b1; bus.tx_wdata = 32'hB5; bus.tx_ready = 1'b1;
    tick();
    bus.tx_wr = 1'b0; bus.tx_ready = 1'b0;
    checks++;
    if (bus.tx_count !== 3'd4 || bus.tx_full !== 1'b1)
      $display("FAIL pp_count: count=%0d full=%b, want 4 1", bus.tx_count, bus.tx_full);
    else passes++;
    expect_tx_head("pp_head", 32'hA2);
    pop_tx(); expect_tx_head("pp_a3", 32'hA3);
    pop_tx(); expect_tx_head("pp_a4", 32'hA4);
    pop_tx(); expect_tx_head("pp_b5", 32'hB5);
    pop_tx();
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_count !== 3'd0 || bus.ovf !== (STAT ? 2'b01 : 2'b00))
      $display("FAIL pp_empty: valid=%b count=%0d ovf=%b", bus.tx_valid, bus.tx_count, bus.ovf);
    else passes++;
  endtask

  task automatic test_underflow_clr();
    bus.rx_ready = 1'b1; tick(); bus.rx_ready = 1'b0;
    checks++;
    if (bus.udf !== (STAT ? 2'b10 : 2'b00) || bus.rx_count !== 3'd0)
      $display("FAIL udf_flag: udf=%b rx_count=%0d, want %b 0", bus.udf, bus.rx_count, STAT ? 2'b10 : 2'b00);
    else passes++;
    push_tx(32'h55); push_tx(32'h66);
    clr_i = 1'b1; bus.tx_wr = 1'b1; bus.tx_wdata = 32'h77; bus.tx_ready = 1'b1;
    tick();
    clr_i = 1'b0; bus.tx_wr = 1'b0; bus.tx_ready = 1'b0;
    checks++;
    if (bus.ovf !== 2'b00 || bus.udf !== 2'b00)
      $display("FAIL clr_flags: ovf=%b udf=%b, want 00 00", bus.ovf, bus.udf);
    else passes++;
    checks++;
    if (bus.tx_count !== 3'd0 || bus.tx_valid !== 1'b0 || bus.tx_rdata !== 32'h0)
      $display("FAIL clr_flush: count=%0d valid=%b data=%h, want 0 0 0", bus.tx_count, bus.tx_valid, bus.tx_rdata);
    else passes++;
    push_tx(32'h88);
    expect_tx_head("clr_restart", 32'h88);
    pop_tx();
  endtask

  task automatic test_interleave();
    push_tx(32'hC1); push_tx(32'hC2); push_tx(32'hC3);
    bus.rx_wr = 1'b1; bus.rx_wdata = 32'h11; bus.tx_ready = 1'b1;
    tick();
    bus.rx_wdata = 32'h22;
    checks++;
    if (bus.rx_count !== 3'd1 || bus.tx_count !== 3'd2)
      $display("FAIL il_step1: rx=%0d tx=%0d, want 1 2", bus.rx_count, bus.tx_count);
    else passes++;
    expect_tx_head("il_tx_c2", 32'hC2);
    tick();
    bus.rx_wr = 1'b0; bus.tx_ready = 1'b0;
    checks++;
    if (bus.rx_count !== 3'd2 || bus.rx_valid !== 1'b1 || bus.rx_rdata !== 32'h11 || bus.rx_full !== 1'b0)
      $display("FAIL il_rx: count=%0d valid=%b data=%h full=%b, want 2 1 11 0",
               bus.rx_count, bus.rx_valid, bus.rx_rdata, bus.rx_full);
    else passes++;
    checks++;
    if (bus.tx_count !== 3'd1 || bus.tx_full !== 1'b0)
      $display("FAIL il_tx_count: count=%0d full=%b, want 1 0", bus.tx_count, bus.tx_full);
    else passes++;
    expect_tx_head("il_tx_c3", 32'hC3);
    bus.rx_ready = 1'b1; tick(); bus.rx_ready = 1'b0;
    checks++;
    if (bus.rx_rdata !== 32'h22 || bus.rx_count !== 3'd1 || bus.tx_count !== 3'd1)
      $display("FAIL il_rx_pop: data=%h rx=%0d tx=%0d, want 22 1 1", bus.rx_rdata, bus.rx_count, bus.tx_count);
    else passes++;
  endtask

  initial begin
    bus.tx_wr = 1'b0; bus.tx_wdata = '0; bus.tx_ready = 1'b0;
    bus.rx_wr = 1'b0; bus.rx_wdata = '0; bus.rx_ready = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow_clr();
    test_interleave();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
